// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed-latency read response FSM.
// Optional macro DMEM_ALIGN_CHECK_EN rejects requests whose i_addr[2:0] is nonzero.
module data_mem_responder #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32,
    parameter int LAT    = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_MemRead,
    input  logic              i_MemWrite,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_valid_data,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic              o_error
);

    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = (LAT > 1) ? 4'(LAT - 2) : 4'd0;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we;
    logic [IDX_W-1:0]  req_idx;
    logic              misaligned;
    logic              unused_addr;

    assign req_idx     = i_addr[IDX_W+2:3];
    assign unused_addr = ^{i_addr[ADDR_W-1:IDX_W+3], i_addr[2:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    logic error_q, error_d;

    assign misaligned = |i_addr[2:0];
    assign error_d    = (state_q == ST_IDLE) && (i_MemRead || i_MemWrite) && misaligned;
    assign o_error    = error_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end
`else
    assign misaligned = 1'b0;
    assign o_error    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mem_we  = 1'b0;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                // Write wins over a simultaneous read; the read is dropped.
                if ((i_MemRead || i_MemWrite) && !misaligned) begin
                    if (i_MemWrite) begin
                        mem_we = 1'b1;
                    end else begin
                        idx_d = req_idx;
                        if (LAT == 1) begin
                            state_d = ST_RESP;
                        end else begin
                            cnt_d   = CNT_INIT;
                            state_d = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        valid_d = (state_d == ST_RESP);
        busy_d  = (state_d != ST_IDLE);
        if (state_d == ST_RESP) begin
            rdata_d = mem_q[idx_d];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[req_idx] <= i_wdata;
        end
    end

    assign o_valid_data = valid_q;
    assign o_rdata      = rdata_q;
    assign o_busy       = busy_q;

endmodule
